// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Shared constants and types for the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {A,B,C,D,E,F,G}; entry 0 is the rightmost element of the literal.
    localparam logic [15:0][6:0] GLYPH_ROM = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic [0:0] {
        SHOW = 1'b0,
        DEAD = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_glyph
// Brief    : Hex nibble plus blank flag to active-low segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = i_blank ? SEG_OFF : GLYPH_ROM[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Multiplexed common-anode seven-segment driver with frame-aligned
//            buffer commit and dead time. Optional leading-zero suppression
//            via SEVEN_SEG_SCAN_LZS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame
);

    localparam int c_span_a   = (REFRESH_DIV > 2) ? REFRESH_DIV : 2;
    localparam int c_span     = (DEAD_CYCLES > c_span_a) ? DEAD_CYCLES : c_span_a;
    localparam int c_cnt_w    = $clog2(c_span);
    localparam int c_idx_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_cnt_w-1:0]    c_show_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_dead_last = c_cnt_w'(DEAD_CYCLES - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one       = NUM_DIGITS'(1);

    scan_state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]        r_idx, w_idx_nxt;
    logic [c_cnt_w-1:0]        r_cnt, w_cnt_nxt;
    logic                      w_advance, w_wrap, w_frame_nxt, w_lit;
    logic [4*NUM_DIGITS-1:0]   r_pend_val, r_disp_val;
    logic [NUM_DIGITS-1:0]     r_pend_blank, r_disp_blank, w_dark;
    logic                      r_dirty;
    logic [6:0]                w_glyph_seg, w_seg_nxt, r_seg;
    logic [NUM_DIGITS-1:0]     w_anode_nxt, r_anode;
    logic                      r_frame;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_advance   = 1'b0;
        w_frame_nxt = 1'b0;
        if (enable) begin
            case (r_state)
                SHOW: begin
                    if (r_cnt == c_show_last) begin
                        w_cnt_nxt   = '0;
                        w_frame_nxt = (r_idx == c_idx_last);
                        if (DEAD_CYCLES == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_nxt = DEAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                DEAD: begin
                    if (r_cnt == c_dead_last) begin
                        w_cnt_nxt   = '0;
                        w_advance   = 1'b1;
                        w_state_nxt = SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                default: w_state_nxt = SHOW;
            endcase
            if (w_advance) begin
                w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            end
        end
    end

    // Frame start: the index is about to wrap from the last digit back to 0.
    assign w_wrap = w_advance && (r_idx == c_idx_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SHOW;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A load coinciding with the commit lands in pending and keeps dirty set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_val   <= '0;
            r_pend_blank <= '1;
            r_disp_val   <= '0;
            r_disp_blank <= '1;
            r_dirty      <= 1'b0;
        end else begin
            if (w_wrap && r_dirty) begin
                r_disp_val   <= r_pend_val;
                r_disp_blank <= r_pend_blank;
            end
            if (load) begin
                r_pend_val   <= value;
                r_pend_blank <= blank;
                r_dirty      <= 1'b1;
            end else if (w_wrap && r_dirty) begin
                r_dirty <= 1'b0;
            end
        end
    end

`ifdef SEVEN_SEG_SCAN_LZS_EN
    logic [NUM_DIGITS-1:0] w_lzs;
    always_comb begin : p_lzs
        logic v_above_zero;
        w_lzs        = '0;
        v_above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lzs[i]     = v_above_zero && (r_disp_val[4*i +: 4] == 4'h0);
            v_above_zero = v_above_zero &&
                           ((r_disp_val[4*i +: 4] == 4'h0) || r_disp_blank[i]);
        end
    end
    assign w_dark = r_disp_blank | w_lzs;
`else
    assign w_dark = r_disp_blank;
`endif

    seven_seg_glyph u_glyph (
        .i_nibble (r_disp_val[int'(r_idx)*4 +: 4]),
        .i_blank  (w_dark[r_idx]),
        .o_seg    (w_glyph_seg)
    );

    assign w_lit       = enable && (r_state == SHOW);
    assign w_anode_nxt = w_lit ? ~(c_one << r_idx) : '1;
    assign w_seg_nxt   = w_lit ? w_glyph_seg : SEG_OFF;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg   <= SEG_OFF;
            r_anode <= '1;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_anode <= w_anode_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign seg   = r_seg;
    assign anode = r_anode;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Brief    : Directed self-checking bench for seven_seg_scan (4 digits,
//            4-cycle lit interval, 2-cycle dead time, 24-cycle frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam logic [6:0] G_OFF = 7'b1111111;
    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0111000;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .DEAD_CYCLES (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .value  (value),
        .load   (load),
        .blank  (blank),
        .enable (enable),
        .seg    (seg),
        .anode  (anode),
        .frame  (frame)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 24-cycle frame; exp_seg holds the lit pattern for digits {3,2,1,0}.
    // Up to two loads ({blank,value}) at slots ka/kb; enable drops for 10 cycles at hold_k.
    task automatic run_frame(input int fnum, input logic [3:0][6:0] exp_seg,
                             input int ka, input logic [19:0] la,
                             input int kb, input logic [19:0] lb,
                             input int hold_k);
        for (int k = 0; k < 24; k++) begin
            int         d;
            int         q;
            logic [3:0] exp_an;
            logic [6:0] exp_sg;
            if (k == hold_k) begin
                enable = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    tick();
                    check_eq($sformatf("f%0d_hold%0d_anode", fnum, h), 32'(anode), 32'hF);
                    check_eq($sformatf("f%0d_hold%0d_seg", fnum, h), 32'(seg), 32'(G_OFF));
                    check_eq($sformatf("f%0d_hold%0d_frame", fnum, h), 32'(frame), 32'h0);
                end
                enable = 1'b1;
            end
            if (k == ka) begin
                load = 1'b1;
                {blank, value} = la;
            end else if (k == kb) begin
                load = 1'b1;
                {blank, value} = lb;
            end
            tick();
            load = 1'b0;
            d = k / 6;
            q = k % 6;
            exp_an = (q < 4) ? ~(4'b0001 << d) : 4'hF;
            exp_sg = (q < 4) ? exp_seg[d[1:0]] : G_OFF;
            check_eq($sformatf("f%0d_k%0d_anode", fnum, k), 32'(anode), 32'(exp_an));
            check_eq($sformatf("f%0d_k%0d_seg", fnum, k), 32'(seg), 32'(exp_sg));
            check_eq($sformatf("f%0d_k%0d_frame", fnum, k), 32'(frame), 32'(k == 21));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        value  = '0;
        blank  = '0;
        enable = 1'b1;
        tick();
        tick();
        check_eq("reset_anode", 32'(anode), 32'hF);
        check_eq("reset_seg", 32'(seg), 32'(G_OFF));
        check_eq("reset_frame", 32'(frame), 32'h0);
        reset = 1'b0;

        // Display stays dark until the first commit; 12AF loaded on the first edge.
        run_frame(0, {G_OFF, G_OFF, G_OFF, G_OFF}, 0, {4'b0000, 16'h12AF}, -1, 20'h0, -1);
        // Mid-frame load of 0000 must not disturb the current frame.
        run_frame(1, {G1, G2, GA, GF}, 8, {4'b0000, 16'h0000}, -1, 20'h0, -1);
        // 3456 loaded mid-frame, then 8888 (digit 2 blanked) on the wrap cycle.
`ifdef SEVEN_SEG_SCAN_LZS_EN
        run_frame(2, {G_OFF, G_OFF, G_OFF, G0}, 10, {4'b0000, 16'h3456},
                  23, {4'b0100, 16'h8888}, -1);
`else
        run_frame(2, {G0, G0, G0, G0}, 10, {4'b0000, 16'h3456},
                  23, {4'b0100, 16'h8888}, -1);
`endif
        // Old pending shows; scan freezes for 10 cycles during digit 2.
        run_frame(3, {G3, G4, G5, G6}, -1, 20'h0, -1, 20'h0, 13);
        run_frame(4, {G8, G_OFF, G8, G8}, -1, 20'h0, -1, 20'h0, -1);
        run_frame(5, {G8, G_OFF, G8, G8}, 2, {4'b0000, 16'h0050}, -1, 20'h0, -1);
`ifdef SEVEN_SEG_SCAN_LZS_EN
        run_frame(6, {G_OFF, G_OFF, G5, G0}, -1, 20'h0, -1, 20'h0, -1);
`else
        run_frame(6, {G0, G0, G5, G0}, -1, 20'h0, -1, 20'h0, -1);
`endif

        // Reset mid-scan with a simultaneous load that must be discarded.
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        blank = 4'b0000;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check_eq("midreset_anode", 32'(anode), 32'hF);
        check_eq("midreset_seg", 32'(seg), 32'(G_OFF));
        check_eq("midreset_frame", 32'(frame), 32'h0);
        run_frame(7, {G_OFF, G_OFF, G_OFF, G_OFF}, -1, 20'h0, -1, 20'h0, -1);
        run_frame(8, {G_OFF, G_OFF, G_OFF, G_OFF}, -1, 20'h0, -1, 20'h0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
